xor_implies_solver: RTL and testbench

Sequential witness-search controller wrapped around the 16-input xor-implies formula evaluator. Given a fixed 8-bit input assignment X (formula inputs i_0..i_7), it sweeps candidate output assignments Y (formula inputs i_8..i_15) one per cycle. It either stops at the first Y that satisfies the formula or counts all satisfying Ys. It sits between the benchmark harness, which issues start/x_in, and the combinational evaluator, and is used to produce reference Skolem witnesses and model counts for checking synthesized functions.

---
 rtl/xor_implies_solver_pkg.sv | 13 +
 rtl/xor_implies_solver_if.sv | 24 ++
 rtl/xor_implies_solver_eval.sv | 20 ++
 rtl/xor_implies_solver.sv | 110 +++++++++++
 tb/tb_xor_implies_solver.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/xor_implies_solver_pkg.sv
// Shared constants and FSM state type for the xor-implies witness solver.
package xor_implies_pkg;
  localparam int NX    = 8;
  localparam int NY    = 8;
  localparam int NIMP  = 4;
  localparam int CNT_W = NY + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/xor_implies_solver_if.sv
// Harness-facing control/result bundle of the witness solver.
interface xor_implies_solver_if;
  import xor_implies_pkg::*;

  logic             start;
  logic             mode_count;
  logic             abort;
  logic [NX-1:0]    x_in;
  logic             busy;
  logic             done;
  logic             found;
  logic [NY-1:0]    y_out;
  logic [CNT_W-1:0] count;

  modport master (
    output start, mode_count, abort, x_in,
    input  busy, done, found, y_out, count
  );

  modport slave (
    input  start, mode_count, abort, x_in,
    output busy, done, found, y_out, count
  );
endinterface

// File: rtl/xor_implies_solver_eval.sv
// Combinational xor-implies formula: parity of all inputs ANDed with NIMP
// implications i_k -> i_(NX+NY-1-k).
module xor_implies_eval #(
  parameter int NX   = 8,
  parameter int NY   = 8,
  parameter int NIMP = 4
) (
  input  logic [NX+NY-1:0] in_vec,
  output logic             out
);
  logic imp_ok;

  always_comb begin
    imp_ok = 1'b1;
    for (int k = 0; k < NIMP; k++) begin
      imp_ok = imp_ok & (~in_vec[k] | in_vec[NX+NY-1-k]);
    end
    out = (^in_vec) & imp_ok;
  end
endmodule

// File: rtl/xor_implies_solver.sv
// Witness-search controller: sweeps every Y for a latched X, stopping at the
// first satisfying Y (find mode) or counting all of them (count mode).
module xor_implies_solver
  import xor_implies_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  xor_implies_solver_if.slave bus
);
  state_e           state_q, state_d;
  logic [NX-1:0]    x_q, x_d;
  logic             mode_q, mode_d;
  logic [NY:0]      y_cnt_q, y_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             found_q, found_d;
  logic [NY-1:0]    y_out_q, y_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             hit;

  xor_implies_eval #(
    .NX   (NX),
    .NY   (NY),
    .NIMP (NIMP)
  ) u_eval (
    .in_vec ({y_cnt_q[NY-1:0], x_q}),
    .out    (hit)
  );

  // The extra top bit of y_cnt marks the wrapped cycle after the last
  // candidate; no candidate is evaluated there, the sweep just closes.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    mode_d  = mode_q;
    y_cnt_d = y_cnt_q;
    count_d = count_q;
    found_d = found_q;
    y_out_d = y_out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = bus.x_in;
          mode_d  = bus.mode_count;
          y_cnt_d = '0;
          count_d = '0;
          found_d = 1'b0;
          y_out_d = '0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (bus.abort) begin
          count_d = '0;
          found_d = 1'b0;
          y_out_d = '0;
          state_d = IDLE;
        end else if (y_cnt_q[NY]) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          y_cnt_d = y_cnt_q + (NY+1)'(1);
          if (hit) begin
            count_d = count_q + CNT_W'(1);
            found_d = 1'b1;
            y_out_d = y_cnt_q[NY-1:0];
            if (!mode_q) begin
              done_d  = 1'b1;
              state_d = DONE;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == EVAL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      mode_q  <= 1'b0;
      y_cnt_q <= '0;
      count_q <= '0;
      found_q <= 1'b0;
      y_out_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      y_cnt_q <= y_cnt_d;
      count_q <= count_d;
      found_q <= found_d;
      y_out_q <= y_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.found = found_q;
  assign bus.y_out = y_out_q;
  assign bus.count = count_q;
endmodule

// File: tb/tb_xor_implies_solver.sv
// Self-checking bench for xor_implies_solver with a brute-force reference model.
module tb_xor_implies_solver;
  import xor_implies_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  xor_implies_solver_if bus ();

  xor_implies_solver dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       found;
    logic [7:0] y;
    logic [8:0] cnt;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  bit         obs_ok;
  logic       obs_found, obs_busy, obs_done_after;
  logic [7:0] obs_y;
  logic [8:0] obs_cnt;
  int         obs_lat;
  logic       ab_pre_found, ab_busy, ab_found;
  logic [7:0] ab_y;
  logic [8:0] ab_cnt;

  // Reference: exhaustive sweep of Y in increasing order.
  function automatic exp_t model(input logic [7:0] x, input bit cnt_mode);
    exp_t        e;
    logic [15:0] v;
    bit          ok;
    e.found = 1'b0;
    e.y     = 8'h00;
    e.cnt   = 9'd0;
    e.lat   = 2 + 256;
    for (int y = 0; y < 256; y++) begin
      v  = {y[7:0], x};
      ok = ^v;
      for (int k = 0; k < 4; k++) if (v[k] && !v[15-k]) ok = 1'b0;
      if (ok) begin
        e.found = 1'b1;
        e.y     = y[7:0];
        e.cnt   = e.cnt + 9'd1;
        if (!cnt_mode) begin
          e.lat = 2 + y;
          break;
        end
      end
    end
    return e;
  endfunction

  // Issues one start; optionally injects an extra start (inj) or abort (ab)
  // at loop index c, where index c corresponds to cycle T+1+c.
  task automatic do_run(input logic [7:0] x, input bit m, input bit push,
                        input int inj, input int ab);
    int c;
    if (push) sb.push_back(model(x, m));
    bus.x_in       = x;
    bus.mode_count = m;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    obs_ok = 1'b0;
    c = 0;
    while (c < 300) begin
      if (c == ab) ab_pre_found = bus.found;
      if (c == ab + 1) begin
        ab_busy  = bus.busy;
        ab_found = bus.found;
        ab_y     = bus.y_out;
        ab_cnt   = bus.count;
      end
      if (bus.done) begin
        obs_ok    = 1'b1;
        obs_lat   = c + 1;
        obs_found = bus.found;
        obs_y     = bus.y_out;
        obs_cnt   = bus.count;
        obs_busy  = bus.busy;
        break;
      end
      bus.start = (c == inj);
      if (c == inj) begin
        bus.x_in       = 8'h00;
        bus.mode_count = 1'b1;
      end
      bus.abort = (c == ab);
      @(posedge clk); #1;
      c++;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    if (obs_ok) begin
      @(posedge clk); #1;
      obs_done_after = bus.done;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.mode_count = 1'b0; bus.x_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b expected 0", bus.done); end
    n_tests++; if (bus.found !== 1'b0) begin n_fail++; $display("FAIL reset_found got %b expected 0", bus.found); end
    n_tests++; if (bus.y_out !== 8'h00) begin n_fail++; $display("FAIL reset_y_out got %h expected 00", bus.y_out); end
    n_tests++; if (bus.count !== 9'd0) begin n_fail++; $display("FAIL reset_count got %0d expected 0", bus.count); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_find();
    logic [7:0] xs [5];
    exp_t e;
    xs[0] = 8'h00; xs[1] = 8'h0F; xs[2] = 8'h01;
    xs[3] = 8'($urandom_range(0, 255)); xs[4] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 5; i++) begin
      do_run(xs[i], 1'b0, 1'b1, -1, -1);
      e = sb.pop_front();
      n_tests++;
      if (!obs_ok) begin n_fail++; $display("FAIL find_timeout x=%h got no done expected done", xs[i]); end
      else begin
        n_tests++; if (obs_found !== e.found) begin n_fail++; $display("FAIL find_found x=%h got %b expected %b", xs[i], obs_found, e.found); end
        n_tests++; if (obs_y !== e.y) begin n_fail++; $display("FAIL find_y x=%h got %h expected %h", xs[i], obs_y, e.y); end
        n_tests++; if (obs_cnt !== e.cnt) begin n_fail++; $display("FAIL find_count x=%h got %0d expected %0d", xs[i], obs_cnt, e.cnt); end
        n_tests++; if (obs_lat !== e.lat) begin n_fail++; $display("FAIL find_latency x=%h got T+%0d expected T+%0d", xs[i], obs_lat, e.lat); end
        n_tests++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL find_busy_at_done x=%h got %b expected 0", xs[i], obs_busy); end
        n_tests++; if (obs_done_after !== 1'b0) begin n_fail++; $display("FAIL find_done_width x=%h got %b expected 0", xs[i], obs_done_after); end
      end
    end
  endtask

  task automatic test_count();
    logic [7:0] xs [4];
    exp_t e;
    xs[0] = 8'h00; xs[1] = 8'h0F; xs[2] = 8'h01; xs[3] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 4; i++) begin
      do_run(xs[i], 1'b1, 1'b1, -1, -1);
      e = sb.pop_front();
      n_tests++;
      if (!obs_ok) begin n_fail++; $display("FAIL count_timeout x=%h got no done expected done", xs[i]); end
      else begin
        n_tests++; if (obs_found !== e.found) begin n_fail++; $display("FAIL count_found x=%h got %b expected %b", xs[i], obs_found, e.found); end
        n_tests++; if (obs_y !== e.y) begin n_fail++; $display("FAIL count_y x=%h got %h expected %h", xs[i], obs_y, e.y); end
        n_tests++; if (obs_cnt !== e.cnt) begin n_fail++; $display("FAIL count_count x=%h got %0d expected %0d", xs[i], obs_cnt, e.cnt); end
        n_tests++; if (obs_lat !== e.lat) begin n_fail++; $display("FAIL count_latency x=%h got T+%0d expected T+%0d", xs[i], obs_lat, e.lat); end
        n_tests++; if (obs_done_after !== 1'b0) begin n_fail++; $display("FAIL count_done_width x=%h got %b expected 0", xs[i], obs_done_after); end
      end
    end
  endtask

  task automatic test_abort();
    do_run(8'h00, 1'b1, 1'b0, 4, 9);
    n_tests++; if (obs_ok) begin n_fail++; $display("FAIL abort_no_done got done at T+%0d expected none", obs_lat); end
    n_tests++; if (ab_pre_found !== 1'b1) begin n_fail++; $display("FAIL abort_pre_found got %b expected 1", ab_pre_found); end
    n_tests++; if (ab_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b expected 0", ab_busy); end
    n_tests++; if (ab_found !== 1'b0) begin n_fail++; $display("FAIL abort_found got %b expected 0", ab_found); end
    n_tests++; if (ab_y !== 8'h00) begin n_fail++; $display("FAIL abort_y got %h expected 00", ab_y); end
    n_tests++; if (ab_cnt !== 9'd0) begin n_fail++; $display("FAIL abort_count got %0d expected 0", ab_cnt); end
  endtask

  task automatic test_start_ignored();
    exp_t e;
    do_run(8'h0F, 1'b0, 1'b1, 3, -1);
    e = sb.pop_front();
    n_tests++;
    if (!obs_ok) begin n_fail++; $display("FAIL ignored_timeout got no done expected done"); end
    else begin
      n_tests++; if (obs_y !== e.y) begin n_fail++; $display("FAIL ignored_y got %h expected %h", obs_y, e.y); end
      n_tests++; if (obs_cnt !== e.cnt) begin n_fail++; $display("FAIL ignored_count got %0d expected %0d", obs_cnt, e.cnt); end
      n_tests++; if (obs_lat !== e.lat) begin n_fail++; $display("FAIL ignored_latency got T+%0d expected T+%0d", obs_lat, e.lat); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [7:0] xs [2];
    xs[0] = 8'h01; xs[1] = 8'h00;
    for (int i = 0; i < 2; i++) begin
      do_run(xs[i], 1'b0, 1'b1, -1, -1);
      e = sb.pop_front();
      n_tests++;
      if (!obs_ok) begin n_fail++; $display("FAIL b2b_timeout x=%h got no done expected done", xs[i]); end
      else begin
        n_tests++; if (obs_y !== e.y) begin n_fail++; $display("FAIL b2b_y x=%h got %h expected %h", xs[i], obs_y, e.y); end
        n_tests++; if (obs_lat !== e.lat) begin n_fail++; $display("FAIL b2b_latency x=%h got T+%0d expected T+%0d", xs[i], obs_lat, e.lat); end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bus.x_in = 8'h00; bus.mode_count = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (49) begin @(posedge clk); #1; end
    n_tests++; if (bus.found !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_found got %b expected 1", bus.found); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b expected 0", bus.busy); end
    n_tests++; if (bus.found !== 1'b0) begin n_fail++; $display("FAIL midrst_found got %b expected 0", bus.found); end
    n_tests++; if (bus.y_out !== 8'h00) begin n_fail++; $display("FAIL midrst_y got %h expected 00", bus.y_out); end
    n_tests++; if (bus.count !== 9'd0) begin n_fail++; $display("FAIL midrst_count got %0d expected 0", bus.count); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_run(8'h0F, 1'b1, 1'b1, -1, -1);
    e = sb.pop_front();
    n_tests++;
    if (!obs_ok) begin n_fail++; $display("FAIL midrst_rerun_timeout got no done expected done"); end
    else begin
      n_tests++; if (obs_cnt !== e.cnt) begin n_fail++; $display("FAIL midrst_rerun_count got %0d expected %0d", obs_cnt, e.cnt); end
      n_tests++; if (obs_y !== e.y) begin n_fail++; $display("FAIL midrst_rerun_y got %h expected %h", obs_y, e.y); end
    end
  endtask

  initial begin
    test_reset();
    test_find();
    test_count();
    test_abort();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
